// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
//   Shared types for the operand-forwarding / hazard unit.
//   fwd_state_t : memory-wait stall FSM states.
//   fwd_src_t   : which source drove a resolved operand (for visibility).
//   REG_AW      : architectural register address width.
// ---------------------------------------------------------------------------
package fwd_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_WAIT,
    FS_ERR
  } fwd_state_t;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_S4,
    SRC_S5,
    SRC_HIST,
    SRC_RF
  } fwd_src_t;

endpackage

// File: rtl/fwd_port_mux.sv
// ---------------------------------------------------------------------------
// fwd_port_mux
//   Priority operand select for one read port:
//   x0 -> stage 4 -> stage 5 -> write-back history -> register file.
// Ports:
//   rd_addr, rf_data              : requested register and its RF read data
//   valid4/addr4/data4            : stage-4 destination and result
//   valid5/addr5/data5            : stage-5 destination and result
//   hist_valid/hist_addr/hist_data: one-entry write-back history
//   src, data                     : selected source and resolved operand
// ---------------------------------------------------------------------------
module fwd_port_mux
  import fwd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              valid4,
  input  logic [REG_AW-1:0] addr4,
  input  logic [XLEN-1:0]   data4,
  input  logic              valid5,
  input  logic [REG_AW-1:0] addr5,
  input  logic [XLEN-1:0]   data5,
  input  logic              hist_valid,
  input  logic [REG_AW-1:0] hist_addr,
  input  logic [XLEN-1:0]   hist_data,
  output fwd_src_t          src,
  output logic [XLEN-1:0]   data
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    src = SRC_RF;
    if (rd_addr == '0)                              src = SRC_ZERO;
    else if (valid4 && (addr4 == rd_addr))          src = SRC_S4;
    else if (valid5 && (addr5 == rd_addr))          src = SRC_S5;
    else if (hist_valid && (hist_addr == rd_addr))  src = SRC_HIST;
  end

  always_comb begin
    data = rf_data;
    case (src)
      SRC_ZERO: data = '0;
      SRC_S4:   data = data4;
      SRC_S5:   data = data5;
      SRC_HIST: data = hist_data;
      default:  data = rf_data;
    endcase
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// ---------------------------------------------------------------------------
// forward_hazard_unit
//   Operand forwarding for NUM_RD execute read ports plus the memory-wait
//   stall FSM and its sticky timeout.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   RdAddr/RdDataIn          : per-port register address and RF read data
//   RdDataOut                : per-port resolved operand (combinational)
//   AddrD4..DataMem4         : stage-4 destination, enable, select, results
//   IsLoad4, MemReady4       : stage-4 load flag and memory data valid
//   AddrD5..DataMem5         : stage-5 (write-back) destination and results
//   Hold                     : freeze stages 1-4, bubble into stage 5
//   MemTimeout               : sticky memory-timeout error
// ---------------------------------------------------------------------------
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_RD       = 2,
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD-1:0][REG_AW-1:0]    RdAddr,
  input  logic [NUM_RD-1:0][XLEN-1:0]      RdDataIn,
  output logic [NUM_RD-1:0][XLEN-1:0]      RdDataOut,
  input  logic [REG_AW-1:0]                AddrD4,
  input  logic                             RDValid4,
  input  logic                             WBSel4,
  input  logic [XLEN-1:0]                  DataALU4,
  input  logic [XLEN-1:0]                  DataMem4,
  input  logic                             IsLoad4,
  input  logic                             MemReady4,
  input  logic [REG_AW-1:0]                AddrD5,
  input  logic                             RDValid5,
  input  logic                             WBSel5,
  input  logic [XLEN-1:0]                  DataALU5,
  input  logic [XLEN-1:0]                  DataMem5,
  output logic                             Hold,
  output logic                             MemTimeout
);

  localparam int CW = $clog2(MEM_WAIT_MAX);

  logic [XLEN-1:0]   data4, data5;
  logic              hist_valid;
  logic [REG_AW-1:0] hist_addr;
  logic [XLEN-1:0]   hist_data;
  fwd_state_t        state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              mem_stall;

  assign data4 = WBSel4 ? DataALU4 : DataMem4;
  assign data5 = WBSel5 ? DataALU5 : DataMem5;

  // Per-port source kept as a named net so it shows up on waveforms.
  fwd_src_t port_src_unused [NUM_RD];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_mux #(.XLEN(XLEN)) u_mux (
      .rd_addr    (RdAddr[p]),
      .rf_data    (RdDataIn[p]),
      .valid4     (RDValid4),
      .addr4      (AddrD4),
      .data4      (data4),
      .valid5     (RDValid5),
      .addr5      (AddrD5),
      .data5      (data5),
      .hist_valid (hist_valid),
      .hist_addr  (hist_addr),
      .hist_data  (hist_data),
      .src        (port_src_unused[p]),
      .data       (RdDataOut[p])
    );
  end

  // Write-back history: remembers the last committed register write so an
  // operand held across a stall still sees stage-5 results that drained
  // meanwhile. Writes to x0 are never recorded.
  // NOTE: the history data is reset too; it is a single register, and a
  // known value keeps simulation free of X even though hist_valid gates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid <= 1'b0;
      hist_addr  <= '0;
      hist_data  <= '0;
    end else if (RDValid5 && (AddrD5 != '0) && (state != FS_ERR)) begin
      hist_valid <= 1'b1;
      hist_addr  <= AddrD5;
      hist_data  <= data5;
    end
  end

  assign mem_stall = IsLoad4 & ~MemReady4;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Cnt counts not-ready cycles already spent; the cycle in which it equals
  // MEM_WAIT_MAX-1 is the last one where ready can still be accepted.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      FS_RUN: begin
        if (mem_stall) begin
          state_next = FS_WAIT;
          cnt_next   = CW'(1);
        end
      end
      FS_WAIT: begin
        if (!IsLoad4 || MemReady4) begin
          // Data arrived or the load was squashed.
          state_next = FS_RUN;
          cnt_next   = '0;
        end else if (cnt == CW'(MEM_WAIT_MAX - 1)) begin
          state_next = FS_ERR;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      FS_ERR:  state_next = FS_ERR;
      default: state_next = FS_RUN;
    endcase
  end

  assign Hold       = mem_stall | (state == FS_ERR);
  // Decoded straight from the state flop, so it is glitch-free.
  assign MemTimeout = (state == FS_ERR);

endmodule

// File: tb/tb_forward_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_forward_hazard_unit
//   Directed self-checking bench for forward_hazard_unit with
//   XLEN=32, NUM_RD=2, MEM_WAIT_MAX=4. Inputs change at the falling edge,
//   outputs are sampled 2 time units later, well clear of the rising edge.
// ---------------------------------------------------------------------------
module tb_forward_hazard_unit;

  localparam int XLEN   = 32;
  localparam int NUM_RD = 2;
  localparam int WMAX   = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_RD-1:0][4:0]        RdAddr;
  logic [NUM_RD-1:0][XLEN-1:0]   RdDataIn;
  logic [NUM_RD-1:0][XLEN-1:0]   RdDataOut;
  logic [4:0]                    AddrD4, AddrD5;
  logic                          RDValid4, WBSel4, IsLoad4, MemReady4;
  logic                          RDValid5, WBSel5;
  logic [XLEN-1:0]               DataALU4, DataMem4, DataALU5, DataMem5;
  logic                          Hold, MemTimeout;

  int n_checks = 0;
  int n_fail   = 0;

  forward_hazard_unit #(
    .XLEN(XLEN), .NUM_RD(NUM_RD), .MEM_WAIT_MAX(WMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .RdAddr(RdAddr), .RdDataIn(RdDataIn), .RdDataOut(RdDataOut),
    .AddrD4(AddrD4), .RDValid4(RDValid4), .WBSel4(WBSel4),
    .DataALU4(DataALU4), .DataMem4(DataMem4),
    .IsLoad4(IsLoad4), .MemReady4(MemReady4),
    .AddrD5(AddrD5), .RDValid5(RDValid5), .WBSel5(WBSel5),
    .DataALU5(DataALU5), .DataMem5(DataMem5),
    .Hold(Hold), .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    RdAddr    = '0;
    RdDataIn  = '0;
    AddrD4    = '0; RDValid4 = 1'b0; WBSel4 = 1'b1;
    DataALU4  = '0; DataMem4 = '0;
    IsLoad4   = 1'b0; MemReady4 = 1'b0;
    AddrD5    = '0; RDValid5 = 1'b0; WBSel5 = 1'b1;
    DataALU5  = '0; DataMem5 = '0;
  endtask

  task automatic start_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  // Stage-4 load of x5 from memory, ready as given.
  task automatic load_x5(input logic ready, input logic [31:0] mem);
    IsLoad4 = 1'b1; RDValid4 = 1'b1; AddrD4 = 5'd5; WBSel4 = 1'b0;
    MemReady4 = ready; DataMem4 = mem;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // ---- reset state -----------------------------------------------------
    @(negedge clk);
    RdAddr[0] = 5'd9; RdDataIn[0] = 32'h1234;
    settle();
    check("rst_hold", Hold, 0);
    check("rst_timeout", MemTimeout, 0);
    check("rst_rf", RdDataOut[0], 32'h1234);

    // ---- priority: stage 4 over stage 5, two ports different sources ----
    start_cycle(); rst = 1'b0;
    RdAddr[0] = 5'd3; RdDataIn[0] = 32'h99;
    RdAddr[1] = 5'd4; RdDataIn[1] = 32'h44;
    RDValid4 = 1'b1; AddrD4 = 5'd3; WBSel4 = 1'b1; DataALU4 = 32'h11;
    RDValid5 = 1'b1; AddrD5 = 5'd3; WBSel5 = 1'b1; DataALU5 = 32'h22;
    settle();
    check("prio_s4", RdDataOut[0], 32'h11);
    check("prio_p1_rf", RdDataOut[1], 32'h44);
    RDValid4 = 1'b0; WBSel5 = 1'b0; DataMem5 = 32'h33;
    #1;
    check("prio_s5_mem", RdDataOut[0], 32'h33);

    // ---- x0 hard-wired; stage-5 write of x0 must not reach history -------
    start_cycle();
    RdAddr[0] = 5'd0; RdDataIn[0] = 32'h5A;
    RDValid4 = 1'b1; AddrD4 = 5'd0; WBSel4 = 1'b1; DataALU4 = 32'hFFFF_FFFF;
    RDValid5 = 1'b1; AddrD5 = 5'd0; DataALU5 = 32'hBAD;
    RdAddr[1] = 5'd3;
    settle();
    check("x0_zero", RdDataOut[0], 32'h0);
    check("hist_x3", RdDataOut[1], 32'h33);
    start_cycle();
    RdAddr[1] = 5'd3;
    settle();
    check("hist_x3_keep", RdDataOut[1], 32'h33);

    // ---- history latency 1 cycle ----------------------------------------
    start_cycle();
    RDValid5 = 1'b1; AddrD5 = 5'd7; DataALU5 = 32'hAB;
    start_cycle();
    RdAddr[1] = 5'd7; RdDataIn[1] = 32'h0;
    RdAddr[0] = 5'd2; RdDataIn[0] = 32'h2222;
    settle();
    check("hist_x7", RdDataOut[1], 32'hAB);
    check("hist_p0_rf", RdDataOut[0], 32'h2222);

    // ---- same-cycle history write and read: stage 5 wins ----------------
    start_cycle();
    RDValid5 = 1'b1; AddrD5 = 5'd7; DataALU5 = 32'hCD;
    RdAddr[1] = 5'd7;
    settle();
    check("same_cyc_s5", RdDataOut[1], 32'hCD);
    start_cycle();
    RdAddr[1] = 5'd7;
    settle();
    check("same_cyc_hist", RdDataOut[1], 32'hCD);

    // ---- memory wait: ready 0,0,1; stage 5 drains x6 during the stall ---
    start_cycle();
    load_x5(1'b0, 32'h0); RdAddr[0] = 5'd5;
    RDValid5 = 1'b1; AddrD5 = 5'd6; DataALU5 = 32'h66;
    settle();
    check("mw_hold0", Hold, 1);
    start_cycle();
    load_x5(1'b0, 32'h0); RdAddr[0] = 5'd5;
    settle();
    check("mw_hold1", Hold, 1);
    start_cycle();
    load_x5(1'b1, 32'h55); RdAddr[0] = 5'd5;
    RdAddr[1] = 5'd6; RdDataIn[1] = 32'h600;
    settle();
    check("mw_hold2", Hold, 0);
    check("mw_data", RdDataOut[0], 32'h55);
    check("mw_drain_hist", RdDataOut[1], 32'h66);
    start_cycle();
    settle();
    check("mw_after_hold", Hold, 0);
    check("mw_after_tmo", MemTimeout, 0);

    // ---- timeout: ready never asserted ----------------------------------
    for (int k = 0; k < 6; k++) begin
      start_cycle();
      load_x5(1'b0, 32'h0);
      settle();
      check($sformatf("tmo_hold_%0d", k), Hold, 1);
      check($sformatf("tmo_flag_%0d", k), MemTimeout, (k >= WMAX) ? 1 : 0);
    end
    // ERR is absorbing, holds without a load, and blocks history writes.
    start_cycle();
    RDValid5 = 1'b1; AddrD5 = 5'd7; DataALU5 = 32'hEE;
    settle();
    check("err_hold", Hold, 1);
    check("err_flag", MemTimeout, 1);
    start_cycle();
    RdAddr[0] = 5'd6; RdDataIn[0] = 32'h600;
    settle();
    check("err_no_hist_wr", RdDataOut[0], 32'h66);

    // ---- reset out of ERR ------------------------------------------------
    start_cycle(); rst = 1'b1;
    start_cycle(); rst = 1'b0;
    RdAddr[0] = 5'd6; RdDataIn[0] = 32'h600;
    settle();
    check("rst_err_flag", MemTimeout, 0);
    check("rst_err_hold", Hold, 0);
    check("rst_err_hist", RdDataOut[0], 32'h600);

    // ---- ready in cycle MAX-1 is accepted --------------------------------
    for (int k = 0; k < WMAX; k++) begin
      start_cycle();
      load_x5((k == WMAX - 1), 32'h77); RdAddr[0] = 5'd5;
      settle();
      check($sformatf("late_hold_%0d", k), Hold, (k == WMAX - 1) ? 0 : 1);
    end
    check("late_data", RdDataOut[0], 32'h77);
    start_cycle();
    settle();
    check("late_flag", MemTimeout, 0);

    // ---- reset mid-WAIT restores the full budget and clears history ------
    start_cycle();
    load_x5(1'b0, 32'h0);
    RDValid5 = 1'b1; AddrD5 = 5'd8; DataALU5 = 32'h88;
    start_cycle();
    load_x5(1'b0, 32'h0);
    settle();
    check("midw_hold", Hold, 1);
    start_cycle(); rst = 1'b1;
    for (int k = 0; k < WMAX; k++) begin
      start_cycle(); rst = 1'b0;
      load_x5((k == WMAX - 1), 32'h99);
      if (k == 0) begin
        RdAddr[1] = 5'd8; RdDataIn[1] = 32'h800;
      end
      settle();
      if (k == 0) check("midw_hist_clr", RdDataOut[1], 32'h800);
      check($sformatf("midw_flag_%0d", k), MemTimeout, 0);
      check($sformatf("midw_hold_%0d", k), Hold, (k == WMAX - 1) ? 0 : 1);
    end
    start_cycle();
    settle();
    check("midw_final_flag", MemTimeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Parametrised operand-forwarding and hazard unit for the 5-stage pipeline. It serves `NUM_RD` operand read ports at the execute input. Each operand is resolved in priority order from stage 4, then stage 5, then a one-entry write-back history register, then the register file. It also stalls the pipeline while a stage-4 load waits on a multi-cycle data memory, and latches a sticky error if that wait exceeds a bound.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NUM_RD`, 2: operand read ports.
- `MEM_WAIT_MAX`, 8: not-ready cycles tolerated before timeout (≥2).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `RdAddr`  in  `[NUM_RD][5]`  operand register address, per port.
- `RdDataIn`  in  `[NUM_RD][XLEN]`  register-file read data, per port.
- `RdDataOut`  out  `[NUM_RD][XLEN]`  resolved operand, per port.
- `AddrD4`, `RDValid4`, `WBSel4`  in  5/1/1  stage-4 destination, write-enable, result select (1 = ALU).
- `DataALU4`, `DataMem4`  in  `XLEN`  stage-4 results.
- `IsLoad4`, `MemReady4`  in  1/1  stage-4 load flag; memory data valid this cycle.
- `AddrD5`, `RDValid5`, `WBSel5`, `DataALU5`, `DataMem5`  in  as stage 4  stage-5 (write-back) results.
- `Hold`  out  1  freeze stages 1–4 and inject a bubble into stage 5.
- `MemTimeout`  out  1  sticky memory-timeout error.

## Operation
Forwarding is combinational and independent per port.
- `Data4 = WBSel4 ? DataALU4 : DataMem4`; `Data5` is formed the same way from the stage-5 inputs.
- Priority for each port:
  - `RdAddr == 0` → 0.
  - else `RDValid4 & AddrD4 == RdAddr` → `Data4`.
  - else `RDValid5 & AddrD5 == RdAddr` → `Data5`.
  - else `HistValid & HistAddr == RdAddr` → `HistData`.
  - else → `RdDataIn`.
- History register: at each edge with `RDValid5 & AddrD5 != 0` and state ≠ ERR, load `HistAddr <= AddrD5`, `HistData <= Data5`, `HistValid <= 1`. Otherwise retain. A retained entry stays correct because every later write to that register also passes through the history register.

Stall FSM, with states RUN, WAIT, ERR and wait counter `Cnt` (width `$clog2(MEM_WAIT_MAX)`):
- `MemStall = IsLoad4 & ~MemReady4`.
- RUN: if `MemStall`, go to WAIT with `Cnt <= 1`.
- WAIT:
  - `MemReady4` → RUN, `Cnt <= 0`.
  - else if `Cnt == MEM_WAIT_MAX-1` → ERR.
  - else `Cnt++`.
  - `~IsLoad4` (load squashed) → RUN, `Cnt <= 0`.
- ERR: absorbing; only `rst` leaves it.
- `Hold = MemStall | (state == ERR)`. This is combinational: asserted in the same cycle the not-ready load is seen.
- `MemTimeout = (state == ERR)`, registered.

## Timing
- Reset values:
  - State RUN, `Cnt` 0, `HistValid` 0, `HistAddr` 0, `HistData` 0, `MemTimeout` 0.
  - `Hold` then follows `MemStall`.
  - `RdDataOut` is combinational and has no reset value of its own.
- Forwarding latency is 0 cycles. History latency is 1 cycle: a stage-5 write at edge N is visible from cycle N+1.
- `MemStall` over cycles 0..k-1 and `MemReady4` in cycle k: `Hold` is high in cycles 0..k-1 and low in cycle k. `RdDataOut` carries `DataMem4` in cycle k.
- Timeout: `MemReady4` low for `MEM_WAIT_MAX` consecutive cycles (cycles 0..MAX-1) → ERR and `MemTimeout` high from cycle MAX. Ready in cycle MAX-1 is still accepted.
- During `Hold`, stage 5 drains. Its write is captured in the history register, so the held stage-3 operand remains correct after the stall.
- Simultaneous history write and read of the same address in the same cycle: the stage-5 match has priority, so the old history value is never used.
- `rst` mid-WAIT or in ERR → RUN next cycle, `MemTimeout` 0, history invalidated.
- Two ports may resolve from different sources in the same cycle.

## Structure
- Package `fwd_pkg`:
  - `typedef enum {FS_RUN, FS_WAIT, FS_ERR} fwd_state_t`.
  - `typedef enum {SRC_ZERO, SRC_S4, SRC_S5, SRC_HIST, SRC_RF} fwd_src_t`.
- Sub-module `fwd_port_mux`: the per-port priority select producing `fwd_src_t` and data. It is instantiated `NUM_RD` times by generate.
- The FSM, counter and history register live in the top module.

## Test plan
- Priority: `RdAddr[0]=3`, stage 4 ALU writes x3=0x11, stage 5 writes x3=0x22 → 0x11. Drop stage 4 with `WBSel5=0`, `DataMem5=0x33` → 0x33.
- x0: `RdAddr=0`, `AddrD4=0`, `RDValid4=1`, `DataALU4=0xFFFFFFFF` → 0.
- History: stage 5 writes x7=0xAB at edge N. In cycle N+1, port 1 reads x7 with no stage-4/5 match and `RdDataIn=0` → 0xAB, while port 0 reads x2 (no match) → `RdDataIn`.
- Memory wait: `IsLoad4=1`, `AddrD4=5`, `WBSel4=0`, `MemReady4` 0,0,1 with `DataMem4=0x55`, port 0 reads x5 → `Hold` 1,1,0; `RdDataOut[0]=0x55` in cycle 2.
- Timeout with `MEM_WAIT_MAX=4`: ready never asserted → `Hold` high throughout, `MemTimeout` rises in cycle 4 and stays high. `rst` → `MemTimeout` 0, state RUN.
- Reset mid-WAIT after 2 stall cycles, then a fresh not-ready load → the full `MEM_WAIT_MAX` budget is available again (`Cnt` restarted), and `HistValid` is 0.
